// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state encoding, BCD digit constants and range helper for bin_to_bcd_seq
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int               BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD    = 4'd3;

  // 10^n as a constant function, used to reject DIGITS too small for IN_W at elaboration
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: double-dabble digit correction, adds 3 to a BCD digit that is 5 or more
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] q_o
);

  // A digit >= 5 would exceed 9 after the upcoming doubling, so pre-correct it
  always_comb q_o = (d_i >= ADJ_THRESH) ? d_i + ADJ_ADD : d_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-and-add-3 binary to BCD converter, one bit per clock; BCD_AUTO_RESTART_EN makes it free-run
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_W   = 9,
  parameter int DIGITS = 3
) (
  input  logic                          Clock,
  input  logic                          Resetn,
  input  logic                          start,
  input  logic [IN_W-1:0]               bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

  localparam int ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  if (pow10(DIGITS) <= ((64'd1 << IN_W) - 64'd1)) begin : g_range_err
    $error("bin_to_bcd_seq: DIGITS too small to hold the largest IN_W-bit value");
  end

  state_e            state_q;
  logic [IN_W-1:0]   shreg_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  adj;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;
  logic [ACC_W-1:0]  bcd_q;
  logic              go;

`ifdef BCD_AUTO_RESTART_EN
  assign go = 1'b1;
`else
  assign go = start;
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d_i(acc_q[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q_o(adj[k*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Control FSM with datapath and registered busy/done/bcd outputs
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go) begin
            shreg_q <= bin;
            acc_q   <= '0;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          {acc_q, shreg_q} <= {adj, shreg_q} << 1;
          cnt_q            <= cnt_q - 1'b1;
          if (cnt_q == CNT_LAST) state_q <= DONE;
        end
        DONE: begin
          bcd_q   <= acc_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: table, random and corner-sequence checks of bin_to_bcd_seq against a decimal model
module tb_bin_to_bcd_seq;

  localparam int IN_W   = 9;
  localparam int DIGITS = 3;
  localparam int LAT    = IN_W + 1;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  bin = '0;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  typedef struct {
    logic [8:0]  v;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[10];

  bin_to_bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .Clock(Clock),
    .Resetn(Resetn),
    .start(start),
    .bin(bin),
    .busy(busy),
    .done(done),
    .bcd(bcd)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) if (done) done_cnt++;

  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic run_conv(input logic [8:0] v, input logic [11:0] exp, input string nm);
    int lat;
    int bc;
    bin = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    bc = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      tick();
      lat++;
    end
    chk({nm, "_latency"}, lat, LAT);
    chk({nm, "_busy_cycles"}, bc, LAT);
    chk({nm, "_bcd"}, bcd, exp);
    chk({nm, "_busy_at_done"}, busy, 0);
    tick();
    chk({nm, "_done_single"}, done, 0);
    chk({nm, "_bcd_hold"}, bcd, exp);
  endtask

  initial begin
    int d0;
    logic [8:0] rv;
    vecs[0] = '{9'd0,   12'h000};
    vecs[1] = '{9'd511, 12'h511};
    vecs[2] = '{9'd255, 12'h255};
    vecs[3] = '{9'd109, 12'h109};
    vecs[4] = '{9'd42,  12'h042};
    vecs[5] = '{9'd9,   12'h009};
    vecs[6] = '{9'd10,  12'h010};
    vecs[7] = '{9'd99,  12'h099};
    vecs[8] = '{9'd100, 12'h100};
    vecs[9] = '{9'd500, 12'h500};

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd, 0);
    Resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_quiet", {busy, done, bcd}, 0);
    end

    d0 = done_cnt;
    run_conv(9'd511, 12'h511, "all_ones");
    run_conv(9'd255, 12'h255, "back_to_back");
    chk("two_done_pulses", done_cnt - d0, 2);

    for (int i = 0; i < 10; i++) run_conv(vecs[i].v, vecs[i].exp, "table");

    for (int i = 0; i < 20; i++) begin
      rv = 9'($urandom_range(0, 511));
      run_conv(rv, ref_bcd(int'(rv)), "random");
    end

    d0 = done_cnt;
    bin = 9'd109;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bin = 9'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && !done; i++) tick();
    chk("ignore_start_bcd", bcd, 12'h109);
    repeat (30) tick();
    chk("ignore_start_one_done", done_cnt - d0, 1);
    chk("ignore_start_idle", busy, 0);

    bin = 9'd300;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("mid_busy_before", busy, 1);
    Resetn = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_bcd", bcd, 0);
    chk("abort_done", done, 0);
    tick();
    Resetn = 1'b1;
    repeat (20) tick();
    chk("abort_stays_idle", {busy, done, bcd}, 0);
    run_conv(9'd42, 12'h042, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
